// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Build option IF_MISALIGN_CHK_EN (off by default) adds a misalign flag to each buffered entry.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // One decode-bound entry: instruction word tagged with the pc it was fetched for
  typedef struct packed {
`ifdef IF_MISALIGN_CHK_EN
    logic            misalign;
`endif
    logic [ILEN-1:0] data;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count; DEPTH must be a power of two.
module if_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is reset too so the head reads as zero straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, in-order response tagging and flush with stale-response drop.
// Build option IF_MISALIGN_CHK_EN: a misaligned pc produces a flagged NOP entry instead of a memory request.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [ILEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk_if,
  input  logic            rst_n_if,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_take,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            inst_misalign
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   pcq_count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic            credit_ok;
  logic            misaligned;
  logic            misalign_nop;
  logic            handshake;
  logic            rsp_keep;
  logic            fifo_push;
  logic            fifo_pop;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_head;

  // Buffered entries plus in-flight requests never exceed DEPTH, so a response always has a slot
  assign credit_ok = (SW'(fifo_count) + SW'(outstanding)) < SW'(DEPTH);

`ifdef IF_MISALIGN_CHK_EN
  assign misaligned   = pc_in[1:0] != 2'b00;
  // Only inject once the pipe is empty so the NOP stays in program order
  assign misalign_nop = rst_n_if && !flush && credit_ok && misaligned
                        && (drop_cnt == '0) && (outstanding == '0);
`else
  assign misaligned   = 1'b0;
  assign misalign_nop = 1'b0;
`endif

  assign imem_req_valid = rst_n_if && !flush && credit_ok && !misaligned;
  assign imem_req_addr  = word_addr(pc_in);
  assign handshake      = imem_req_valid && imem_req_ready;
  assign pc_take        = handshake || misalign_nop;

  assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0) && !flush;
  assign fifo_push = rsp_keep || misalign_nop;
  assign fifo_pop  = inst_valid && inst_ready;

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.data = imem_rsp_data;
    fifo_wdata.pc   = pcq_head;
    if (misalign_nop) begin
      fifo_wdata.data = NOP_INST;
      fifo_wdata.pc   = pc_in;
`ifdef IF_MISALIGN_CHK_EN
      fifo_wdata.misalign = 1'b1;
`endif
    end
  end

  // pc of every live request, popped as its response lands
  if_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk   (clk_if),
    .rst_n (rst_n_if),
    .push  (handshake),
    .pop   (rsp_keep && (pcq_count != '0)),
    .clear (flush),
    .wdata (pc_in),
    .rdata (pcq_head),
    .count (pcq_count)
  );

  if_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_inst_fifo (
    .clk   (clk_if),
    .rst_n (rst_n_if),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  // drop_cnt counts pre-flush requests whose responses must be swallowed
  always_ff @(posedge clk_if or negedge rst_n_if) begin
    if (!rst_n_if) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(handshake) - CW'(imem_rsp_valid);
      if (flush) begin
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  assign inst_valid = fifo_count != '0;
  assign inst_data  = fifo_head.data;
  assign inst_pc    = fifo_head.pc;
`ifdef IF_MISALIGN_CHK_EN
  assign inst_misalign = fifo_head.misalign;
`else
  assign inst_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based fetch model and an in-order instruction memory.
// Covers throughput, backpressure, flush with in-flight drops, async reset and (IF_MISALIGN_CHK_EN) misaligned pc.
module tb_if_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk_if = 1'b0;
  logic        rst_n_if;
  logic [31:0] pc_in;
  logic        pc_take;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        inst_misalign;

  if_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk_if         (clk_if),
    .rst_n_if       (rst_n_if),
    .pc_in          (pc_in),
    .pc_take        (pc_take),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .inst_misalign  (inst_misalign)
  );

  always #5 clk_if = ~clk_if;

  typedef struct { logic [31:0] addr; logic [31:0] pc; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        pend[$];
  ent_t        fifo_q[$];
  int          epoch, cyc, last_due, takes;
  int          n_checks, n_pass;
  logic [31:0] cur_pc;
  int unsigned flush_pct, ready_pct, mem_rdy_pct, min_lat, max_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1357;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock: drive at +1, check at the falling edge, then advance the model to the next edge
  task automatic step(input bit force_flush, input logic [31:0] redirect);
    logic        rsp, fl, exp_rv, hs;
    logic [31:0] r;
    req_t        e;
    int          due;
    @(posedge clk_if); #1;
    cyc++;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend[0].addr) : 32'h0;
    fl             = force_flush || ($urandom_range(99) < flush_pct);
    flush          = fl;
    inst_ready     = $urandom_range(99) < ready_pct;
    imem_req_ready = $urandom_range(99) < mem_rdy_pct;
    pc_in          = cur_pc;
    #4;
    exp_rv = !fl && ((pend.size() + fifo_q.size()) < int'(DEPTH));
    hs     = exp_rv && imem_req_ready;
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check_eq("pc_take", 32'(pc_take), 32'(hs));
    if (exp_rv) check_eq("req_addr", imem_req_addr, {cur_pc[31:2], 2'b00});
    check_eq("inst_valid", 32'(inst_valid), 32'(fifo_q.size() != 0));
    check_eq("inst_misalign", 32'(inst_misalign), 32'h0);
    if (fifo_q.size() != 0) begin
      check_eq("inst_pc", inst_pc, fifo_q[0].pc);
      check_eq("inst_data", inst_data, fifo_q[0].data);
      if (inst_ready) void'(fifo_q.pop_front());
    end
    if (fl) begin
      fifo_q.delete();
      epoch++;
    end
    if (rsp) begin
      e = pend.pop_front();
      if (e.epoch == epoch) fifo_q.push_back('{pc: e.pc, data: mem_word(e.addr)});
    end
    if (hs) begin
      due = cyc + int'($urandom_range(max_lat, min_lat));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: {cur_pc[31:2], 2'b00}, pc: cur_pc, epoch: epoch, due: due});
      cur_pc = cur_pc + 32'd4;
      takes++;
    end
    if (fl) begin
      r      = $urandom();
      cur_pc = force_flush ? redirect : {16'h0, r[15:2], 2'b00};
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic set_mode(input int unsigned fp, input int unsigned rp, input int unsigned mp,
                          input int unsigned lo, input int unsigned hi);
    flush_pct = fp; ready_pct = rp; mem_rdy_pct = mp; min_lat = lo; max_lat = hi;
  endtask

  // Async reset asserted mid-cycle; outputs must clear without waiting for a clock edge
  task automatic do_reset();
    @(posedge clk_if); #2;
    rst_n_if = 1'b0;
    flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    #1;
    check_eq("rst_inst_valid", 32'(inst_valid), 32'h0);
    check_eq("rst_inst_data", inst_data, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("rst_pc_take", 32'(pc_take), 32'h0);
    check_eq("rst_misalign", 32'(inst_misalign), 32'h0);
    pend.delete(); fifo_q.delete();
    last_due = 0; cur_pc = 32'h0; pc_in = 32'h0;
    repeat (2) @(posedge clk_if);
    #2 rst_n_if = 1'b1;
  endtask

  initial begin
    rst_n_if = 1'b0; pc_in = '0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    epoch = 0; cyc = 0; last_due = 0; takes = 0; n_checks = 0; n_pass = 0; cur_pc = '0;
    set_mode(0, 100, 100, 1, 1);
    do_reset();

    // Streaming at one instruction per cycle with 1-cycle memory
    run(20);

    // Drain, then stall decode: exactly DEPTH requests may be accepted
    set_mode(0, 100, 0, 1, 1);
    run(6);
    set_mode(0, 0, 100, 1, 1);
    takes = 0;
    run(12);
    check_eq("stall_takes", 32'(takes), 32'(DEPTH));
    set_mode(0, 100, 0, 1, 1);
    run(8);

    // Three in flight at 3-cycle latency, flush lands on a response cycle, redirect to 0x100
    set_mode(0, 100, 100, 3, 3);
    run(3);
    step(1'b1, 32'h100);
    run(12);

    // Toggling memory ready
    set_mode(0, 100, 50, 1, 1);
    run(40);

    // Fully random traffic with flushes and variable latency
    set_mode(6, 60, 60, 1, 4);
    run(1500);

    // Reset with requests outstanding and entries buffered
    set_mode(0, 0, 100, 3, 3);
    run(5);
    do_reset();
    set_mode(5, 70, 70, 1, 3);
    run(500);

`ifdef IF_MISALIGN_CHK_EN
    do_reset();
    @(posedge clk_if); #1;
    pc_in = 32'h6; imem_req_ready = 1'b1; inst_ready = 1'b0; flush = 1'b0;
    #4;
    check_eq("mis_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("mis_pc_take", 32'(pc_take), 32'h1);
    @(posedge clk_if); #1;
    imem_req_ready = 1'b0; pc_in = 32'h8;
    #4;
    check_eq("mis_inst_valid", 32'(inst_valid), 32'h1);
    check_eq("mis_inst_data", inst_data, 32'h0000_0013);
    check_eq("mis_inst_pc", inst_pc, 32'h6);
    check_eq("mis_flag", 32'(inst_misalign), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register in the single-cycle RV32 core.
- Takes the current pc, issues word reads to instruction memory over a valid/ready request channel, and accepts in-order responses.
- Buffers fetched words with their pc in a small FIFO and hands them to decode over a valid/ready channel.
- Supports flush/redirect, discarding stale in-flight responses.

Parameters:
- DEPTH, 4, combined capacity (FIFO entries + outstanding requests); power of two, ≥2; ≥3 required for 1 inst/cycle throughput at 1-cycle memory latency.
- NOP_INST, 32'h0000_0013, word substituted for invalid fetches (addi x0,x0,0).

Ports:
- clk_if  in  1  clock, rising edge.
- rst_n_if  in  1  asynchronous, active-low reset.
- pc_in  in  32  current pc from PC register.
- pc_take  out  1  pulse: request for pc_in accepted; NPC/PC may advance.
- flush  in  1  redirect: discard all buffered and in-flight fetches.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  word address (byte address, [1:0]=0).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; in order; ≥1 cycle after request handshake.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_data  out  32  instruction word.
- inst_pc  out  32  pc of inst_data.
- inst_ready  in  1  decode consumes head.
- inst_misalign  out  1  head came from a misaligned pc (feature only; else tied 0).

Behaviour:
- Reset (rst_n_if low, async): FIFO empty, outstanding=0, drop_cnt=0, pc queue empty. All outputs 0: inst_valid, inst_data, inst_pc, imem_req_valid, pc_take, inst_misalign. Reset mid-operation abandons everything; memory is reset alongside.
- Credit: imem_req_valid = !flush && (fifo_count + outstanding) < DEPTH, using current registered counts.
- imem_req_addr = {pc_in[31:2],2'b00}.
- pc_take = imem_req_valid && imem_req_ready (combinational).
- On handshake: outstanding+1; pc_in pushed to the pc queue (depth DEPTH).
- Response with drop_cnt>0: discarded, drop_cnt-1, outstanding-1, pc queue untouched.
- Response with drop_cnt==0: pc queue popped; {data, pc} written to FIFO; outstanding-1. Registered, so inst_valid rises the cycle after imem_rsp_valid. Best-case latency from request handshake: 2 cycles.
- FIFO pop: inst_valid && inst_ready. Push and pop in the same cycle are allowed, count unchanged. Credit guarantees no overflow, so no response is ever refused.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Flush cycle:
  - FIFO and pc queue cleared.
  - imem_req_valid forced 0.
  - drop_cnt <= outstanding − (imem_rsp_valid?1:0); a response in the flush cycle is itself discarded.
  - outstanding updated normally.
  - inst_valid is 0 from the next cycle.
  - New requests may issue from the next cycle while draining drops; in-order delivery keeps tagging correct.
- Flush while drop_cnt>0: drop_cnt recomputed by the same rule.
- No FSM beyond the counters; control states are IDLE (outstanding=0), BUSY, DRAIN (drop_cnt>0), all implied by counters.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- Defined: pc_in[1:0]!=0 suppresses the memory request. When credit allows and drop_cnt==0 and outstanding==0:
  - pc_take pulses;
  - the FIFO gets {NOP_INST, pc_in} with inst_misalign=1;
  - the FIFO entry is widened by one bit.
- Undefined: pc_in[1:0] ignored (masked in address), inst_misalign tied 0.

Decomposition:
- Shared package/defines.vh: NOP_INST, instruction/address widths, IF_MISALIGN_CHK_EN default off.
- One sub-module: if_sync_fifo (parameterised width/depth, push/pop/clear, count). Instantiated twice: instruction FIFO and pc queue.

Test Plan:
- Reset then pc_in=0x0,4,8…, ready=1, 1-cycle memory, inst_ready=1 → inst_valid from cycle 3; inst_pc sequence 0x0,0x4,0x8 at 1/cycle; pc_take held high.
- inst_ready=0 with DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0; raising inst_ready drains 4 entries in order with correct pc.
- 3 requests outstanding (3-cycle memory latency), flush in a cycle with imem_rsp_valid=1 → drop_cnt=2; next 2 responses never appear on inst_*; first post-flush fetch of pc=0x100 delivered tagged 0x100.
- imem_req_ready toggling 1,0,1,0 → pc_take mirrors handshakes only; no duplicated or skipped pc.
- rst_n_if pulsed low with 2 outstanding and FIFO non-empty → all outputs 0 immediately, asynchronously; fetch restarts cleanly after release.
- IF_MISALIGN_CHK_EN, pc_in=0x6 → no memory request; inst_data=0x00000013, inst_pc=0x6, inst_misalign=1.
